// File: rtl/text_console_writer_if.sv
// Character-stream, screen-RAM and status signals of the text console writer.
// The master modport is the writer side; the slave modport is the host/RAM side.
interface text_console_writer_if;
    logic        charValid;
    logic [7:0]  charData;
    logic [7:0]  charAttr;
    logic        charReady;
    logic        clearReq;
    logic        ramEnable;
    logic [1:0]  ramWriteEnable;
    logic [10:0] ramAddress;
    logic [15:0] ramDataOut;
    logic [15:0] ramDataIn;
    logic [6:0]  cursorCol;
    logic [4:0]  cursorRow;
    logic        busy;

    modport master (
        input  charValid, charData, charAttr, clearReq, ramDataIn,
        output charReady, ramEnable, ramWriteEnable, ramAddress, ramDataOut,
        output cursorCol, cursorRow, busy
    );

    modport slave (
        output charValid, charData, charAttr, clearReq, ramDataIn,
        input  charReady, ramEnable, ramWriteEnable, ramAddress, ramDataOut,
        input  cursorCol, cursorRow, busy
    );
endinterface

// File: rtl/text_console_writer.sv
// Writes a character stream into a word-per-cell screen RAM, handling CR/LF/BS,
// line wrap, scrolling by copying rows upward, and full-screen clear.
module text_console_writer #(
    parameter int unsigned COLUMNS    = 80,
    parameter int unsigned ROWS       = 25,
    parameter logic [7:0]  BLANK_ATTR = 8'h07
) (
    input  logic                  clock,
    input  logic                  reset_n,
    text_console_writer_if.master bus
);

    localparam int unsigned ADDR_W      = 11;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned COL_W       = 7;
    localparam int unsigned ROW_W       = 5;
    localparam int unsigned SLOT_W      = 12;
    localparam int unsigned COPY_WORDS  = (ROWS - 1) * COLUMNS;
    localparam int unsigned TOTAL_WORDS = ROWS * COLUMNS;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    localparam logic [DATA_W-1:0] BLANK_WORD = {BLANK_ATTR, CH_SPACE};
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(ROWS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PUT       = 3'd1;
    localparam logic [2:0] S_SCROLL_RD = 3'd2;
    localparam logic [2:0] S_SCROLL_WR = 3'd3;
    localparam logic [2:0] S_BLANK     = 3'd4;
    localparam logic [2:0] S_CLEAR     = 3'd5;

    logic [2:0]        state_q, state_d;
    logic              sub_q, sub_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              ram_en_q, ram_en_d;
    logic [1:0]        ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;

    logic              adv_row;
    logic              col_wrap;
    logic              copy_done;
    logic              ptr_last;
    logic [ADDR_W-1:0] cell_addr;
    logic [SLOT_W-1:0] slot_word;
    logic              slot_ok;

    assign cell_addr = ADDR_W'(32'(row_q) * COLUMNS + 32'(col_q));
    assign col_wrap  = (32'(col_q) + 32'd1) == COLUMNS;
    assign copy_done = (32'(ptr_q) + 32'd2) >= COPY_WORDS;
    assign ptr_last  = 32'(ptr_q) == (TOTAL_WORDS - 1);

    // Copy runs as pairs: read i, read i+1, write i, write i+1, so each
    // write's data has been captured from ramDataIn into the output register.
    always_comb begin
        state_d    = state_q;
        sub_d      = sub_q;
        ptr_d      = ptr_q;
        col_d      = col_q;
        row_d      = row_q;
        adv_row    = 1'b0;
        ram_en_d   = 1'b0;
        ram_we_d   = 2'b00;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.clearReq) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end else if (bus.charValid) begin
                    case (bus.charData)
                        CH_CR: col_d = '0;
                        CH_LF: begin
                            col_d   = '0;
                            adv_row = 1'b1;
                        end
                        CH_BS: begin
                            if (col_q != '0) col_d = col_q - COL_W'(1);
                        end
                        default: state_d = S_PUT;
                    endcase
                end
            end
            S_PUT: begin
                state_d = S_IDLE;
                if (col_wrap) begin
                    col_d   = '0;
                    adv_row = 1'b1;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            S_SCROLL_RD: begin
                if (!sub_q) begin
                    sub_d = 1'b1;
                end else begin
                    state_d = S_SCROLL_WR;
                    sub_d   = 1'b0;
                end
            end
            S_SCROLL_WR: begin
                if (!sub_q) begin
                    sub_d = 1'b1;
                end else begin
                    sub_d = 1'b0;
                    if (copy_done) begin
                        state_d = S_BLANK;
                        ptr_d   = ADDR_W'(COPY_WORDS);
                    end else begin
                        state_d = S_SCROLL_RD;
                        ptr_d   = ptr_q + ADDR_W'(2);
                    end
                end
            end
            S_BLANK: begin
                if (ptr_last) state_d = S_IDLE;
                else          ptr_d   = ptr_q + ADDR_W'(1);
            end
            S_CLEAR: begin
                if (ptr_last) begin
                    state_d = S_IDLE;
                    col_d   = '0;
                    row_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Advancing past the bottom row keeps the cursor there and scrolls.
        if (adv_row) begin
            if (row_q == ROW_LAST) begin
                state_d = S_SCROLL_RD;
                sub_d   = 1'b0;
                ptr_d   = '0;
            end else begin
                row_d = row_q + ROW_W'(1);
            end
        end

        slot_word = SLOT_W'(ptr_d) + SLOT_W'(sub_d);
        slot_ok   = 32'(slot_word) < COPY_WORDS;

        // RAM port registers carry the access belonging to the next state.
        case (state_d)
            S_PUT: begin
                ram_en_d   = 1'b1;
                ram_we_d   = 2'b11;
                ram_addr_d = cell_addr;
                ram_data_d = {bus.charAttr, bus.charData};
            end
            S_SCROLL_RD: begin
                if (slot_ok) begin
                    ram_en_d   = 1'b1;
                    ram_addr_d = ADDR_W'(32'(slot_word) + COLUMNS);
                end
            end
            S_SCROLL_WR: begin
                if (slot_ok) begin
                    ram_en_d   = 1'b1;
                    ram_we_d   = 2'b11;
                    ram_addr_d = ADDR_W'(slot_word);
                    ram_data_d = bus.ramDataIn;
                end
            end
            S_BLANK, S_CLEAR: begin
                ram_en_d   = 1'b1;
                ram_we_d   = 2'b11;
                ram_addr_d = ptr_d;
                ram_data_d = BLANK_WORD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            sub_q      <= 1'b0;
            ptr_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 2'b00;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            state_q    <= state_d;
            sub_q      <= sub_d;
            ptr_q      <= ptr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
        end
    end

    assign bus.charReady      = (state_q == S_IDLE) && !bus.clearReq;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.ramEnable      = ram_en_q;
    assign bus.ramWriteEnable = ram_we_q;
    assign bus.ramAddress     = ram_addr_q;
    assign bus.ramDataOut     = ram_data_q;
    assign bus.cursorCol      = col_q;
    assign bus.cursorRow      = row_q;

endmodule

// File: doc/text_console_writer.md
TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 The module SHALL have parameter COLUMNS, default 80, giving characters per row.
REQ-002 The module SHALL have parameter ROWS, default 25, giving rows per screen.
REQ-003 The module SHALL have parameter BLANK_ATTR, default 8'h07, giving the attribute used for blank cells.
REQ-004 The module SHALL have port clock  input  1  sole clock; all logic is on its rising edge.
REQ-005 The module SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 The module SHALL have port charValid  input  1  character byte offered.
REQ-007 The module SHALL have port charData  input  8  code point or control byte.
REQ-008 The module SHALL have port charAttr  input  8  attribute, sampled with charData.
REQ-009 The module SHALL have port charReady  output  1  character accepted when charValid and charReady are both high.
REQ-010 The module SHALL have port clearReq  input  1  request to clear the screen.
REQ-011 The module SHALL have port ramEnable  output  1  screen RAM read/write port enable.
REQ-012 The module SHALL have port ramWriteEnable  output  2  byte write enables; bit0 = code point, bit1 = attribute.
REQ-013 The module SHALL have port ramAddress  output  11  word address.
REQ-014 The module SHALL have port ramDataOut  output  16  write data as {attribute, code point}.
REQ-015 The module SHALL have port ramDataIn  input  16  read data, valid one cycle after an enabled read.
REQ-016 The module SHALL have ports cursorCol (output, 7 bits) and cursorRow (output, 5 bits) giving the current cursor position.
REQ-017 The module SHALL have port busy  output  1  high while a write, scroll or clear is in progress.

Function
REQ-018 The module SHALL implement states IDLE, PUT, SCROLL_RD, SCROLL_WR, BLANK and CLEAR.
REQ-019 The module SHALL drive charReady high only in IDLE, and SHALL hold it low in any cycle where clearReq is high.
REQ-020 In IDLE, clearReq SHALL take priority over charValid; clearReq in any other state SHALL be ignored.
REQ-021 Cell address SHALL be cursorRow*COLUMNS+cursorCol; addresses 2000-2047 SHALL never be accessed.
REQ-022 Byte 0x0D (CR) SHALL set cursorCol to 0 with no RAM access and return to IDLE on the next cycle.
REQ-023 Byte 0x0A (LF) SHALL set cursorCol to 0 and advance the row.
REQ-024 Byte 0x08 (BS) SHALL decrement cursorCol if it is nonzero and SHALL do nothing at column 0; it SHALL never wrap to the previous row and SHALL cause no RAM access.
REQ-025 Any other byte SHALL be accepted in cycle N, and in cycle N+1 (state PUT) the module SHALL drive ramEnable=1, ramWriteEnable=2'b11, ramAddress=cell address and ramDataOut={charAttr,charData}, then increment cursorCol.
REQ-026 When cursorCol reaches COLUMNS, cursorCol SHALL become 0 and the row SHALL advance.
REQ-027 A row advance with cursorRow<ROWS-1 SHALL increment cursorRow; with cursorRow=ROWS-1, cursorRow SHALL remain ROWS-1 and a scroll SHALL start.
REQ-028 During a scroll, for i=0..(ROWS-1)*COLUMNS-1, SCROLL_RD SHALL read address i+COLUMNS (write enables 0) and the following SCROLL_WR SHALL write the returned ramDataIn to address i.
REQ-029 After the copy, BLANK SHALL write {BLANK_ATTR,8'h20} to the last row, one word per cycle, and SHALL then return to IDLE; the default total scroll duration is 3920 cycles.
REQ-030 CLEAR SHALL write {BLANK_ATTR,8'h20} to addresses 0..ROWS*COLUMNS-1, one per cycle (2000 cycles by default), SHALL set the cursor to (0,0) at completion, and SHALL then return to IDLE.
REQ-031 ramEnable SHALL be high only in cycles issuing an access; ramWriteEnable SHALL be 0 whenever ramEnable is 0.
REQ-032 busy SHALL be high in every non-IDLE state.
REQ-033 All outputs except charReady and busy SHALL be registered.
REQ-034 A printable character accepted with cursor (79,24) SHALL be written at 1999 before the scroll begins.

Reset
REQ-035 While reset_n is low, the module SHALL immediately hold state=IDLE, cursor=(0,0), ramEnable=0, ramWriteEnable=0, ramAddress=0 and ramDataOut=0, and SHALL abort any scroll or clear; RAM contents SHALL not be cleared by reset.
REQ-036 charReady SHALL be 1 and busy SHALL be 0 in the first cycle after reset_n rises.

Verification
REQ-037 Reset, then send 0x41 with attribute 0x1E -> exactly one write at address 0 with data 16'h1E41 and enables 2'b11; cursor becomes (1,0).
REQ-038 Send 80 printable bytes from (0,0) -> writes at addresses 0..79 and cursor (0,1), with no scroll.
REQ-039 Preload address 80 with 16'hABCD, set the cursor to row 24, then send LF -> busy is high for 3920 cycles; address 0 = 16'hABCD; addresses 1920-1999 = 16'h0720; cursor (0,24).
REQ-040 Pulse clearReq together with charValid -> the character is not accepted; 2000 writes of 16'h0720 follow; the cursor ends at (0,0).
REQ-041 At column 0, send BS; then send CR at column 5 -> the cursor ends at column 0 and ramEnable is never asserted.
REQ-042 Assert reset_n low 100 cycles into a scroll -> ramEnable drops immediately; after release, the cursor is (0,0), busy is 0 and charReady is 1.
